// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter
//   Quadrature (A/B) encoder front end: input synchronisers, x4 decode, signed
//   wrapping position counter, windowed signed velocity measurement with a
//   one-cycle valid strobe, direction flag and sticky illegal-transition flag.
//
//   Optional build macro: ENC_INDEX_EN adds the index input Z. A rising edge of
//   the synchronised Z zeroes POS (the step of that cycle is discarded from POS).
//
// Parameters
//   POS_W       position width (signed, wraps)
//   VEL_W       velocity / window accumulator width (signed, saturates)
//   CLK_DIV     CLK cycles per prescaler tick (>=2)
//   WINDOW      prescaler ticks per velocity window (>=1)
//   SYNC_STAGES synchroniser depth for every asynchronous pin (>=2)
//
// Ports
//   CLK        in   system clock, posedge
//   RST_N      in   asynchronous active-low reset
//   A, B       in   encoder channels, asynchronous
//   CLR        in   synchronous clear of position/velocity/error/timers
//   Z          in   index pulse (ENC_INDEX_EN only), asynchronous
//   POS        out  signed position, one count per quadrature edge
//   VEL        out  signed edge count of the last complete window
//   VEL_VALID  out  one-cycle strobe when VEL is updated
//   DIR        out  direction of last valid step (1 = +, 0 = -)
//   ERR        out  sticky illegal transition (both channels changed)
module quad_encoder_counter #(
  parameter int POS_W       = 32,
  parameter int VEL_W       = 16,
  parameter int CLK_DIV     = 3200,
  parameter int WINDOW      = 21,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    A,
  input  logic                    B,
  input  logic                    CLR,
`ifdef ENC_INDEX_EN
  input  logic                    Z,
`endif
  output logic signed [POS_W-1:0] POS,
  output logic signed [VEL_W-1:0] VEL,
  output logic                    VEL_VALID,
  output logic                    DIR,
  output logic                    ERR
);

  localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

  // Gray-code phase of the two channels: 00,01,11,10 -> 0,1,2,3.
  function automatic logic [1:0] gray_to_idx(input logic [1:0] g);
    logic [1:0] idx;
    case (g)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      2'b10:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Signed accumulate of a -1/0/+1 step with clamping to the VEL_W range.
  function automatic logic signed [VEL_W-1:0] sat_add(
    input logic signed [VEL_W-1:0] acc,
    input logic signed [1:0]       step
  );
    logic signed [VEL_W:0] sum;
    logic signed [VEL_W-1:0] res;
    sum = {acc[VEL_W-1], acc} + {{(VEL_W-1){step[1]}}, step};
    if (sum[VEL_W] != sum[VEL_W-1]) begin
      res = sum[VEL_W] ? VEL_MIN : VEL_MAX;
    end else begin
      res = sum[VEL_W-1:0];
    end
    return res;
  endfunction

  logic [SYNC_STAGES-1:0] a_sync_r;
  logic [SYNC_STAGES-1:0] b_sync_r;
  logic                   a_s;
  logic                   b_s;
  logic                   a_prev_r;
  logic                   b_prev_r;
  logic                   prime_r;
  logic [PS_W-1:0]        presc_r;
  logic [WIN_W-1:0]       win_r;
  logic signed [VEL_W-1:0] acc_r;
  logic signed [1:0]      step_s;
  logic                   illegal_s;
  logic [1:0]             phase_diff_s;
  logic                   tick_s;
  logic                   window_end_s;
  logic                   pos_zero_s;

  assign a_s          = a_sync_r[SYNC_STAGES-1];
  assign b_s          = b_sync_r[SYNC_STAGES-1];
  assign tick_s       = (presc_r == PS_LAST);
  assign window_end_s = tick_s && (win_r == WIN_LAST);

  // Channel synchronisers; they keep running through CLR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_sync_r <= '0;
      b_sync_r <= '0;
    end else begin
      a_sync_r <= {a_sync_r[SYNC_STAGES-2:0], A};
      b_sync_r <= {b_sync_r[SYNC_STAGES-2:0], B};
    end
  end

`ifdef ENC_INDEX_EN
  logic [SYNC_STAGES-1:0] z_sync_r;
  logic                   z_prev_r;
  logic                   z_s;

  assign z_s        = z_sync_r[SYNC_STAGES-1];
  assign pos_zero_s = z_s & ~z_prev_r;

  // Index synchroniser and edge-detect history.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      z_sync_r <= '0;
      z_prev_r <= 1'b0;
    end else begin
      z_sync_r <= {z_sync_r[SYNC_STAGES-2:0], Z};
      z_prev_r <= z_s;
    end
  end
`else
  assign pos_zero_s = 1'b0;
`endif

  // x4 decode: modular phase difference 1 = forward, 3 = reverse, 2 = illegal.
  always_comb begin
    step_s       = 2'sd0;
    illegal_s    = 1'b0;
    phase_diff_s = gray_to_idx({a_s, b_s}) - gray_to_idx({a_prev_r, b_prev_r});
    if (prime_r) begin
      step_s    = 2'sd0;
      illegal_s = 1'b0;
    end else begin
      case (phase_diff_s)
        2'd1:    step_s = 2'sd1;
        2'd3:    step_s = -2'sd1;
        2'd2:    illegal_s = 1'b1;
        default: step_s = 2'sd0;
      endcase
    end
  end

  // Previous-phase register, position, direction and error flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_prev_r <= 1'b0;
      b_prev_r <= 1'b0;
      prime_r  <= 1'b1;
      POS      <= '0;
      DIR      <= 1'b0;
      ERR      <= 1'b0;
    end else if (CLR) begin
      prime_r  <= 1'b1;
      POS      <= '0;
      DIR      <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      // While primed the decode yields no step, so this only loads the phase.
      prime_r  <= 1'b0;
      a_prev_r <= a_s;
      b_prev_r <= b_s;
      if (pos_zero_s) begin
        POS <= '0;
      end else begin
        POS <= POS + {{(POS_W-2){step_s[1]}}, step_s};
      end
      if (step_s == 2'sd1) begin
        DIR <= 1'b1;
      end else if (step_s == -2'sd1) begin
        DIR <= 1'b0;
      end
      if (illegal_s) begin
        ERR <= 1'b1;
      end
    end
  end

  // Gate timing: prescaler ticks and the window counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_r <= '0;
      win_r   <= '0;
    end else if (CLR) begin
      presc_r <= '0;
      win_r   <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
      win_r   <= (win_r == WIN_LAST) ? '0 : win_r + 1'b1;
    end else begin
      presc_r <= presc_r + 1'b1;
    end
  end

  // Window accumulator; the boundary-cycle step closes into the finished window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_r     <= '0;
      VEL       <= '0;
      VEL_VALID <= 1'b0;
    end else if (CLR) begin
      acc_r     <= '0;
      VEL       <= '0;
      VEL_VALID <= 1'b0;
    end else if (window_end_s) begin
      VEL       <= sat_add(acc_r, step_s);
      acc_r     <= '0;
      VEL_VALID <= 1'b1;
    end else begin
      acc_r     <= sat_add(acc_r, step_s);
      VEL_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
module tb_quad_encoder_counter;

  localparam int PW  = 16;
  localparam int VW  = 8;
  localparam int SS  = 2;
  localparam int WIN = 5;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic A = 1'b0;
  logic B = 1'b0;
  logic CLR = 1'b0;
`ifdef ENC_INDEX_EN
  logic Z = 1'b0;
`endif

  logic [PW-1:0] pos0, pos1;
  logic [VW-1:0] vel0, vel1;
  logic vv0, vv1, dir0, dir1, err0, err1;

  always #5 CLK = ~CLK;

  quad_encoder_counter #(.POS_W(PW), .VEL_W(VW), .CLK_DIV(4), .WINDOW(WIN), .SYNC_STAGES(SS)) dut0 (
`ifdef ENC_INDEX_EN
    .Z(Z),
`endif
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .CLR(CLR),
    .POS(pos0), .VEL(vel0), .VEL_VALID(vv0), .DIR(dir0), .ERR(err0)
  );

  quad_encoder_counter #(.POS_W(PW), .VEL_W(VW), .CLK_DIV(64), .WINDOW(WIN), .SYNC_STAGES(SS)) dut1 (
`ifdef ENC_INDEX_EN
    .Z(Z),
`endif
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .CLR(CLR),
    .POS(pos1), .VEL(vel1), .VEL_VALID(vv1), .DIR(dir1), .ERR(err1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: pin-sample history, position, and per-DUT window state.
  logic [1:0]    hist[$];
  logic [1:0]    m_prev;
  logic [PW-1:0] m_pos;
  logic          m_dir, m_err, m_prime;
  int            m_acc[2];
  int            m_vel[2];
  int            m_e[2];
  logic          m_valid[2];
  int            period[2];
`ifdef ENC_INDEX_EN
  logic          zhist[$];
  logic          m_zprev;
`endif
  logic [1:0]    gray[4];

  function automatic int gidx(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(2'b00);
`ifdef ENC_INDEX_EN
    zhist.delete();
    for (int i = 0; i < SS; i++) zhist.push_back(1'b0);
    m_zprev = 1'b0;
`endif
    m_prev = 2'b00; m_pos = '0; m_dir = 1'b0; m_err = 1'b0; m_prime = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_vel[k] = 0; m_e[k] = 0; m_valid[k] = 1'b0;
    end
  endtask

  // One rising edge of the model; inputs are those held over the edge.
  task automatic model_edge();
    logic [1:0] cur;
    int step, d;
    logic ill, rise;
    cur = hist[SS-1];
    hist.push_front({A, B});
    void'(hist.pop_back());
    rise = 1'b0;
`ifdef ENC_INDEX_EN
    rise = zhist[SS-1] && !m_zprev;
    m_zprev = zhist[SS-1];
    zhist.push_front(Z);
    void'(zhist.pop_back());
`endif
    step = 0;
    ill = 1'b0;
    if (!m_prime) begin
      d = (gidx(cur) - gidx(m_prev) + 4) % 4;
      if (d == 1) step = 1;
      else if (d == 3) step = -1;
      else if (d == 2) ill = 1'b1;
    end
    if (CLR) begin
      m_pos = '0; m_dir = 1'b0; m_err = 1'b0; m_prime = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_vel[k] = 0; m_e[k] = 0; m_valid[k] = 1'b0;
      end
    end else begin
      m_prime = 1'b0;
      m_prev = cur;
      m_pos = rise ? '0 : 16'(int'(m_pos) + step);
      if (step == 1) m_dir = 1'b1;
      else if (step == -1) m_dir = 1'b0;
      if (ill) m_err = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_e[k]++;
        if (m_e[k] == period[k]) begin
          m_vel[k] = sat(m_acc[k] + step);
          m_acc[k] = 0; m_e[k] = 0; m_valid[k] = 1'b1;
        end else begin
          m_acc[k] = sat(m_acc[k] + step);
          m_valid[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("pos0", 32'(pos0), 32'(m_pos));
    chk("pos1", 32'(pos1), 32'(m_pos));
    chk("vel0", 32'(vel0), 32'(m_vel[0] & 255));
    chk("vel1", 32'(vel1), 32'(m_vel[1] & 255));
    chk("valid0", 32'(vv0), 32'(m_valid[0]));
    chk("valid1", 32'(vv1), 32'(m_valid[1]));
    chk("dir0", 32'(dir0), 32'(m_dir));
    chk("dir1", 32'(dir1), 32'(m_dir));
    chk("err0", 32'(err0), 32'(m_err));
    chk("err1", 32'(err1), 32'(m_err));
  endtask

  // Advance one clock: model follows the edge, outputs checked at the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (RST_N) begin
      model_edge();
      cyc++;
    end
    @(negedge CLK);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic move(input int dir);
    logic [1:0] nxt;
    nxt = gray[(gidx({A, B}) + dir + 4) % 4];
    A = nxt[1];
    B = nxt[0];
  endtask

  task automatic wait_until(input int n);
    for (int i = 0; i < 1000 && cyc < n; i++) tick();
    chk("wait_cycle", 32'(cyc), 32'(n));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_reset();
    A = 1'b0; B = 1'b0; CLR = 1'b0;
`ifdef ENC_INDEX_EN
    Z = 1'b0;
`endif
    ticks(2);
    chk("rst_pos", 32'(pos0), 32'd0);
    chk("rst_vel", 32'(vel0), 32'd0);
    chk("rst_valid", 32'(vv0), 32'd0);
    RST_N = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int old, c, r;
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    period[0] = 4 * WIN;
    period[1] = 64 * WIN;
    model_reset();
    @(negedge CLK);

    // Forward steps spaced 3 CLK, each visible exactly 3 CLK after the pin change.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      old = int'(pos0);
      move(1);
      ticks(2);
      chk("lat_before", 32'(pos0), 32'(old));
      tick();
      chk("lat_at3", 32'(pos0), 32'(old + 1));
    end
    chk("t1_pos", 32'(pos0), 32'd8);
    chk("t1_dir", 32'(dir0), 32'd1);
    chk("t1_err", 32'(err0), 32'd0);

    // 6 forward then 10 reverse.
    do_reset();
    for (int i = 0; i < 6; i++) begin move(1); ticks(3); end
    for (int i = 0; i < 10; i++) begin move(-1); ticks(3); end
    chk("t2_pos", 32'(pos0), 32'h0000_FFFC);
    chk("t2_dir", 32'(dir0), 32'd0);

    // Velocity window: 7 steps in the first window, then a still window.
    do_reset();
    for (int i = 0; i < 7; i++) begin move(1); ticks(2); end
    wait_until(19);
    chk("t3_nostrobe19", 32'(vv0), 32'd0);
    tick();
    chk("t3_strobe20", 32'(vv0), 32'd1);
    chk("t3_vel7", 32'(vel0), 32'd7);
    tick();
    chk("t3_strobe_once", 32'(vv0), 32'd0);
    wait_until(40);
    chk("t3_strobe40", 32'(vv0), 32'd1);
    chk("t3_vel0", 32'(vel0), 32'd0);

    // Illegal jump sets sticky ERR without counting.
    do_reset();
    move(1); ticks(3);
    move(1); ticks(3);
    A = 1'b0; B = 1'b0; ticks(3);
    chk("t4_err", 32'(err0), 32'd1);
    chk("t4_pos", 32'(pos0), 32'd2);
    move(1); ticks(3);
    chk("t4_pos_after", 32'(pos0), 32'd3);
    chk("t4_err_sticky", 32'(err0), 32'd1);
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("t4_err_clr", 32'(err0), 32'd0);
    tick();

    // 200 steps in one long window saturate VEL on the CLK_DIV=64 instance.
    do_reset();
    for (int i = 0; i < 200; i++) begin move(1); tick(); end
    wait_until(320);
    chk("t5_strobe", 32'(vv1), 32'd1);
    chk("t5_vel_sat", 32'(vel1), 32'd127);
    chk("t5_pos", 32'(pos1), 32'd200);

    // CLR mid-window discards the partial window and restarts gate timing.
    do_reset();
    for (int i = 0; i < 5; i++) begin move(1); ticks(3); end
    tick();
    chk("t6_pos5", 32'(pos0), 32'd5);
    CLR = 1'b1; tick(); CLR = 1'b0;
    c = cyc;
    chk("t6_pos0", 32'(pos0), 32'd0);
    chk("t6_vel0", 32'(vel0), 32'd0);
    wait_until(c + 19);
    chk("t6_nostrobe", 32'(vv0), 32'd0);
    tick();
    chk("t6_strobe", 32'(vv0), 32'd1);
    chk("t6_vel", 32'(vel0), 32'd0);

    // CLR coinciding with a window end suppresses the strobe.
    do_reset();
    wait_until(19);
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("t7_clr_vs_end", 32'(vv0), 32'd0);

`ifdef ENC_INDEX_EN
    // Index edge zeroes POS only.
    do_reset();
    for (int i = 0; i < 9; i++) begin move(1); ticks(3); end
    chk("tz_pos9", 32'(pos0), 32'd9);
    Z = 1'b1; ticks(3);
    chk("tz_pos0", 32'(pos0), 32'd0);
    Z = 1'b0; ticks(2);
`endif

    // Randomised motion with occasional glitches, clears and resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35) move(1);
      else if (r < 60) move(-1);
      else if (r < 62) begin A = ~A; B = ~B; end
      CLR = ($urandom_range(0, 299) == 0);
`ifdef ENC_INDEX_EN
      if ($urandom_range(0, 49) == 0) Z = ~Z;
`endif
      if ($urandom_range(0, 1999) == 0) do_reset();
      tick();
    end
    CLR = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
